// File: rtl/gate_tpd_pkg.sv
// gate_tpd_pkg: shared types and helpers for the delayed gate line.
// Holds the mode/state enums and the per-channel gate function.
package gate_tpd_pkg;

    localparam int DLY_W = 8;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,
        MODE_OR   = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_NAND = 2'd3
    } mode_e;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_e;

    function automatic logic gate_eval(
        input mode_e m,
        input logic  a,
        input logic  b
    );
        logic r;
        unique case (m)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = ~(a & b);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_tpd_chan.sv
// gate_tpd_chan: one inertial-delay channel.
// Target must hold for D+1 sampled edges before c follows it.
module gate_tpd_chan
    import gate_tpd_pkg::*;
#(
    parameter int TPD_LH    = 3,
    parameter int TPD_HL    = 6,
    parameter bit RESET_VAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_mode,
    input  logic       i_a,
    input  logic       i_b,
    output logic       o_c,
    output logic       o_chg,
    output logic       o_pend,
    output logic       o_rej
);

    localparam logic [DLY_W-1:0] LH_M1 = DLY_W'(TPD_LH - 1);
    localparam logic [DLY_W-1:0] HL_M1 = DLY_W'(TPD_HL - 1);

    state_e           r_state;
    state_e           w_state_nx;
    logic [DLY_W-1:0] r_cnt;
    logic             r_pend_val;
    logic             r_c;
    logic             r_chg;
    logic             w_t;
    logic             w_rej;
    logic             w_fire;

    assign w_t = gate_eval(mode_e'(i_mode), i_a, i_b);

    // State register; reset drops any pending transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_STABLE;
        else        r_state <= w_state_nx;
    end

    // Next state: arm on a differing target, leave on fire or revert.
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_STABLE: if (w_t != r_c) w_state_nx = ST_PEND;
            ST_PEND:   if (w_rej || w_fire) w_state_nx = ST_STABLE;
        endcase
    end

    // Output decode: revert and expiry strobes for this edge.
    always_comb begin
        o_pend = (r_state == ST_PEND);
        w_rej  = o_pend && (w_t != r_pend_val);
        w_fire = o_pend && (w_t == r_pend_val) && (r_cnt == '0);
    end

    // Delay counter, pending value and the delayed output itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c        <= RESET_VAL;
            r_chg      <= 1'b0;
            r_cnt      <= '0;
            r_pend_val <= 1'b0;
        end else begin
            r_chg <= 1'b0;
            if (r_state == ST_STABLE) begin
                if (w_t != r_c) begin
                    r_cnt      <= w_t ? LH_M1 : HL_M1;
                    r_pend_val <= w_t;
                end
            end else if (w_fire) begin
                r_c   <= r_pend_val;
                r_chg <= 1'b1;
            end else if (!w_rej) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign o_c   = r_c;
    assign o_chg = r_chg;
    assign o_rej = w_rej;

endmodule

// File: rtl/gate_tpd_line.sv
// gate_tpd_line: WIDTH inertial-delay gate channels.
// Adds the busy OR and a saturating rejected-pulse counter.
module gate_tpd_line
    import gate_tpd_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int TPD_LH    = 3,
    parameter int TPD_HL    = 6,
    parameter bit RESET_VAL = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] chg,
    output logic             busy,
    output logic [CNT_W-1:0] rej_cnt,
    input  logic             clr_cnt
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] SAT = SUM_W'({CNT_W{1'b1}});

    if (TPD_LH < 1 || TPD_LH > 255) begin : g_bad_lh
        $error("gate_tpd_line: TPD_LH must be 1..255");
    end
    if (TPD_HL < 1 || TPD_HL > 255) begin : g_bad_hl
        $error("gate_tpd_line: TPD_HL must be 1..255");
    end

    logic [WIDTH-1:0] w_pend;
    logic [WIDTH-1:0] w_rej;
    logic [PC_W-1:0]  w_pop;
    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] r_rej_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        gate_tpd_chan #(
            .TPD_LH    (TPD_LH),
            .TPD_HL    (TPD_HL),
            .RESET_VAL (RESET_VAL)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_mode (mode),
            .i_a    (a[i]),
            .i_b    (b[i]),
            .o_c    (c[i]),
            .o_chg  (chg[i]),
            .o_pend (w_pend[i]),
            .o_rej  (w_rej[i])
        );
    end

    // Count of channels rejecting at this edge, and the clamped sum.
    always_comb begin
        w_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + PC_W'(w_rej[i]);
        end
        w_sum = SUM_W'(r_rej_cnt) + SUM_W'(w_pop);
        if (w_sum > SAT) w_sum = SAT;
    end

    // Rejection counter; clear beats a simultaneous increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rej_cnt <= '0;
        else if (clr_cnt) r_rej_cnt <= '0;
        else              r_rej_cnt <= CNT_W'(w_sum);
    end

    assign busy    = |w_pend;
    assign rej_cnt = r_rej_cnt;

endmodule

// File: tb/tb_gate_tpd_line.sv
// tb_gate_tpd_line: scoreboard bench for gate_tpd_line.
// dut0 uses defaults; dut1 has RESET_VAL=1 and a 2-bit counter.
module tb_gate_tpd_line;

    logic       clk = 1'b0;
    logic       rst_n, rst1_n;
    logic [1:0] mode, mode1;
    logic [3:0] a, b, a1, b1;
    logic       clr0, clr1;
    logic [3:0] c, chg, c1, chg1;
    logic       busy, busy1;
    logic [15:0] rej;
    logic [1:0]  rej1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_rej = 0;

    typedef struct {
        int         cyc;
        logic [3:0] c;
        logic [3:0] chg;
    } exp_t;

    exp_t q[$];
    exp_t e_m;

    gate_tpd_line dut0 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .a(a), .b(b),
        .c(c), .chg(chg), .busy(busy), .rej_cnt(rej), .clr_cnt(clr0)
    );

    gate_tpd_line #(.RESET_VAL(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst1_n), .mode(mode1), .a(a1), .b(b1),
        .c(c1), .chg(chg1), .busy(busy1), .rej_cnt(rej1), .clr_cnt(clr1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every chg pulse of dut0 must match the queue head.
    always @(negedge clk) begin
        if (chg !== 4'h0) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_chg cyc=%0d chg=%h c=%h", cyc, chg, c);
            end else begin
                e_m = q.pop_front();
                if (e_m.cyc != cyc || c !== e_m.c || chg !== e_m.chg) begin
                    n_fail++;
                    $display("FAIL sb_update cyc=%0d c=%h chg=%h exp cyc=%0d c=%h chg=%h",
                             cyc, c, chg, e_m.cyc, e_m.c, e_m.chg);
                end
            end
        end else if (q.size() > 0 && cyc > q[0].cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL missed_update cyc=%0d exp cyc=%0d c=%h", cyc, q[0].cyc, q[0].c);
            void'(q.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int at, input logic [3:0] cv, input logic [3:0] mv);
        exp_t e;
        e.cyc = at;
        e.c   = cv;
        e.chg = mv;
        q.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 0; rst1_n = 0; clr0 = 0; clr1 = 0;
        mode = 2'd0; a = 4'hF; b = 4'hF;
        mode1 = 2'd0; a1 = 4'hF; b1 = 4'hF;
        repeat (2) step();
        n_chk++;
        if (c !== 4'h0 || chg !== 4'h0 || busy !== 1'b0 || rej !== 16'd0) begin
            n_fail++;
            $display("FAIL reset0 c=%h chg=%h busy=%b rej=%0d exp 0", c, chg, busy, rej);
        end
        n_chk++;
        if (c1 !== 4'hF || chg1 !== 4'h0 || busy1 !== 1'b0 || rej1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset1 c=%h chg=%h busy=%b rej=%0d exp c=f", c1, chg1, busy1, rej1);
        end
        a = 4'h0; b = 4'h0;
        step();
        rst_n = 1; rst1_n = 1;
        step();
        n_chk++;
        if (c !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset c=%h busy=%b exp c=0 busy=0", c, busy);
        end
    endtask

    task automatic test_rise_fall();
        a = 4'hF; b = 4'hF;
        push(cyc + 1 + 3, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (busy !== 1'b1 || c !== 4'h0) begin
                n_fail++;
                $display("FAIL rise_wait%0d busy=%b c=%h exp busy=1 c=0", i, busy, c);
            end
        end
        step();
        n_chk++;
        if (c !== 4'hF || busy !== 1'b0 || chg !== 4'hF) begin
            n_fail++;
            $display("FAIL rise c=%h busy=%b chg=%h exp f/0/f", c, busy, chg);
        end
        step();
        n_chk++;
        if (chg !== 4'h0) begin
            n_fail++;
            $display("FAIL chg_one_cycle chg=%h exp 0", chg);
        end
        a = 4'h0;
        push(cyc + 1 + 6, 4'h0, 4'hF);
        for (int i = 0; i < 6; i++) begin
            step();
            n_chk++;
            if (busy !== 1'b1 || c !== 4'hF) begin
                n_fail++;
                $display("FAIL fall_wait%0d busy=%b c=%h exp busy=1 c=f", i, busy, c);
            end
        end
        step();
        n_chk++;
        if (c !== 4'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fall c=%h busy=%b exp 0/0", c, busy);
        end
    endtask

    task automatic test_inertial();
        a = 4'b0001; b = 4'b0001;
        repeat (2) step();
        a = 4'h0;
        step();
        exp_rej = exp_rej + 1;
        n_chk++;
        if (c !== 4'h0 || busy !== 1'b0 || rej !== 16'(exp_rej)) begin
            n_fail++;
            $display("FAIL reject1 c=%h busy=%b rej=%0d exp 0/0/%0d", c, busy, rej, exp_rej);
        end
        a = 4'hF; b = 4'hF;
        step();
        a = 4'h0;
        step();
        exp_rej = exp_rej + 4;
        n_chk++;
        if (rej !== 16'(exp_rej) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reject4 rej=%0d busy=%b exp %0d/0", rej, busy, exp_rej);
        end
        a = 4'b0001; b = 4'b0001;
        push(cyc + 1 + 3, 4'b0001, 4'b0001);
        repeat (4) step();
        n_chk++;
        if (c !== 4'b0001) begin
            n_fail++;
            $display("FAIL pulse_pass c=%h exp 1", c);
        end
        a = 4'h0;
        push(cyc + 1 + 6, 4'h0, 4'b0001);
        repeat (7) step();
        n_chk++;
        if (c !== 4'h0 || rej !== 16'(exp_rej)) begin
            n_fail++;
            $display("FAIL pulse_end c=%h rej=%0d exp 0/%0d", c, rej, exp_rej);
        end
    endtask

    task automatic test_mode_switch();
        a = 4'hF; b = 4'h0; mode = 2'd0;
        step();
        mode = 2'd2;
        push(cyc + 1 + 3, 4'hF, 4'hF);
        repeat (4) step();
        n_chk++;
        if (c !== 4'hF) begin
            n_fail++;
            $display("FAIL xor_rise c=%h exp f", c);
        end
        mode = 2'd3;
        repeat (3) step();
        n_chk++;
        if (c !== 4'hF || busy !== 1'b0 || chg !== 4'h0) begin
            n_fail++;
            $display("FAIL nand_hold c=%h busy=%b chg=%h exp f/0/0", c, busy, chg);
        end
    endtask

    task automatic test_counter_sat();
        for (int k = 1; k <= 5; k++) begin
            a1 = 4'hE;
            step();
            a1 = 4'hF;
            step();
            n_chk++;
            if (rej1 !== 2'((k > 3) ? 3 : k)) begin
                n_fail++;
                $display("FAIL sat_rej%0d rej=%0d exp %0d", k, rej1, (k > 3) ? 3 : k);
            end
        end
        a1 = 4'hE;
        step();
        a1 = 4'hF;
        clr1 = 1;
        step();
        clr1 = 0;
        n_chk++;
        if (rej1 !== 2'd0) begin
            n_fail++;
            $display("FAIL clr_wins rej=%0d exp 0", rej1);
        end
        a1 = 4'hE;
        step();
        a1 = 4'hF;
        step();
        n_chk++;
        if (rej1 !== 2'd1 || c1 !== 4'hF || busy1 !== 1'b0 || chg1 !== 4'h0) begin
            n_fail++;
            $display("FAIL after_clr rej=%0d c=%h busy=%b chg=%h exp 1/f/0/0",
                     rej1, c1, busy1, chg1);
        end
    endtask

    task automatic test_async_reset();
        mode = 2'd0; a = 4'h0; b = 4'h0;
        rst_n = 0;
        exp_rej = 0;
        step();
        rst_n = 1;
        step();
        a = 4'hF; b = 4'hF;
        repeat (2) step();
        #2;
        rst_n = 0;
        #1;
        n_chk++;
        if (c !== 4'h0 || busy !== 1'b0 || rej !== 16'd0 || chg !== 4'h0) begin
            n_fail++;
            $display("FAIL async_rst c=%h busy=%b rej=%0d chg=%h exp all 0", c, busy, rej, chg);
        end
        step();
        rst_n = 1;
        push(cyc + 1 + 3, 4'hF, 4'hF);
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (busy !== 1'b1 || c !== 4'h0) begin
                n_fail++;
                $display("FAIL rearm_wait%0d busy=%b c=%h exp 1/0", i, busy, c);
            end
        end
        step();
        n_chk++;
        if (c !== 4'hF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_rise c=%h busy=%b exp f/0", c, busy);
        end
    endtask

    initial begin
        test_reset();
        test_rise_fall();
        test_inertial();
        test_mode_switch();
        test_counter_sat();
        test_async_reset();
        repeat (2) step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d exp 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
